// File: rtl/stoch_mul_sched.sv
// Round-robin scheduler for the shared stochastic multiplier: accepts one operand pair at a time,
// reseeds two 31-bit LFSRs and counts product ones over a 2^WIN_LOG2 window. Macro STOCH_BIPOLAR_EN selects XNOR multiply.
module stoch_mul_sched #(
  parameter int unsigned WIN_LOG2 = 3,
  parameter logic [30:0] SEED_A   = 31'd1,
  parameter logic [30:0] SEED_B   = 31'd2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req_valid_i,
  output logic [1:0]          req_ready_o,
  input  logic [7:0]          op0_i,
  input  logic [7:0]          op1_i,
  output logic [1:0]          res_valid_o,
  output logic [WIN_LOG2:0]   res_count_o,
  output logic                busy_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam logic [WIN_LOG2-1:0] LAST_BIT = {WIN_LOG2{1'b1}};

  function automatic logic prod_bit(input logic sa, input logic sb);
`ifdef STOCH_BIPOLAR_EN
    prod_bit = ~(sa ^ sb);
`else
    prod_bit = sa & sb;
`endif
  endfunction

  function automatic logic [30:0] lfsr_step(input logic [30:0] v);
    lfsr_step = {v[29:0], v[27] ^ v[30]};
  endfunction

  state_e              state_q, state_d;
  logic                last_grant_q, last_grant_d;
  logic                owner_q, owner_d;
  logic [3:0]          op_a_q, op_a_d;
  logic [3:0]          op_b_q, op_b_d;
  logic [30:0]         lfsr_a_q, lfsr_a_d;
  logic [30:0]         lfsr_b_q, lfsr_b_d;
  logic [WIN_LOG2-1:0] bit_cnt_q, bit_cnt_d;
  logic [WIN_LOG2:0]   ones_q, ones_d;
  logic [1:0]          res_valid_q, res_valid_d;
  logic [WIN_LOG2:0]   res_count_q, res_count_d;
  logic                busy_q;

  logic                grant_s;
  logic                hs_s;
  logic                sa_s;
  logic                sb_s;
  logic                p_s;
  logic [7:0]          op_sel_s;

  // Round-robin pick: on contention the requester that was not served last wins.
  always_comb begin
    grant_s = 1'b0;
    if (req_valid_i == 2'b11) begin
      grant_s = ~last_grant_q;
    end else if (req_valid_i[1]) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  // Handshake is only offered in IDLE, and only to the granted requester.
  always_comb begin
    req_ready_o = 2'b00;
    if (state_q == S_IDLE) begin
      if (grant_s) begin
        req_ready_o = {req_valid_i[1], 1'b0};
      end else begin
        req_ready_o = {1'b0, req_valid_i[0]};
      end
    end else begin
      req_ready_o = 2'b00;
    end
  end

  // Bitstream comparators and the product bit for the current RUN cycle.
  always_comb begin
    hs_s     = |req_ready_o;
    op_sel_s = grant_s ? op1_i : op0_i;
    sa_s     = (lfsr_a_q[3:0] < op_a_q);
    sb_s     = (lfsr_b_q[3:0] < op_b_q);
    p_s      = prod_bit(sa_s, sb_s);
  end

  // Next-state and datapath updates for the scheduler FSM.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    lfsr_a_d     = lfsr_a_q;
    lfsr_b_d     = lfsr_b_q;
    bit_cnt_d    = bit_cnt_q;
    ones_d       = ones_q;
    res_valid_d  = 2'b00;
    res_count_d  = res_count_q;
    case (state_q)
      S_IDLE: begin
        if (hs_s) begin
          op_a_d       = op_sel_s[3:0];
          op_b_d       = op_sel_s[7:4];
          owner_d      = grant_s;
          last_grant_d = grant_s;
          state_d      = S_LOAD;
        end else begin
          state_d      = S_IDLE;
        end
      end
      S_LOAD: begin
        lfsr_a_d  = SEED_A;
        lfsr_b_d  = SEED_B;
        bit_cnt_d = '0;
        ones_d    = '0;
        state_d   = S_RUN;
      end
      S_RUN: begin
        ones_d    = ones_q + (WIN_LOG2+1)'(p_s);
        lfsr_a_d  = lfsr_step(lfsr_a_q);
        lfsr_b_d  = lfsr_step(lfsr_b_q);
        bit_cnt_d = bit_cnt_q + WIN_LOG2'(1);
        if (bit_cnt_q == LAST_BIT) begin
          // Result strobe is registered so it lines up with the DONE cycle.
          res_valid_d = owner_q ? 2'b10 : 2'b01;
          res_count_d = ones_q + (WIN_LOG2+1)'(p_s);
          state_d     = S_DONE;
        end else begin
          state_d     = S_RUN;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any job in flight.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      op_a_q       <= 4'd0;
      op_b_q       <= 4'd0;
      lfsr_a_q     <= SEED_A;
      lfsr_b_q     <= SEED_B;
      bit_cnt_q    <= '0;
      ones_q       <= '0;
      res_valid_q  <= 2'b00;
      res_count_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      lfsr_a_q     <= lfsr_a_d;
      lfsr_b_q     <= lfsr_b_d;
      bit_cnt_q    <= bit_cnt_d;
      ones_q       <= ones_d;
      res_valid_q  <= res_valid_d;
      res_count_q  <= res_count_d;
      busy_q       <= (state_d != S_IDLE);
    end
  end

  assign res_valid_o = res_valid_q;
  assign res_count_o = res_count_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_stoch_mul_sched.sv
// Directed bench for stoch_mul_sched: table of jobs with hand-computed counts on two configurations,
// plus sequences for round-robin contention, back-to-back throughput and reset abort.
module tb_stoch_mul_sched;

  logic       clk;
  logic       rst_n;
  logic [1:0] valid1, ready1, rv1;
  logic [7:0] op0_1, op1_1;
  logic [3:0] rc1;
  logic       busy1;
  logic [1:0] valid2, ready2, rv2;
  logic [7:0] op0_2, op1_2;
  logic [4:0] rc2;
  logic       busy2;

  logic       cur_sel;
  logic [1:0] ready_m, rv_m;
  logic [4:0] rc_m;
  logic       busy_m;

  int n_total;
  int n_pass;

  typedef struct {
    logic       sel;
    logic       req;
    logic [7:0] op;
    logic [4:0] eu;
    logic [4:0] eb;
    int         lat;
  } vec_t;

  vec_t       vecs[12];
  logic [4:0] res_hist[12];
  logic [1:0] acc_g[4];
  int         acc_t[4];
  int         acc_n;
  logic       saw11;

  stoch_mul_sched #(.WIN_LOG2(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid_i(valid1), .req_ready_o(ready1),
    .op0_i(op0_1), .op1_i(op1_1), .res_valid_o(rv1), .res_count_o(rc1), .busy_o(busy1)
  );

  stoch_mul_sched #(.WIN_LOG2(4), .SEED_A(31'h40000000), .SEED_B(31'h08000000)) dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid_i(valid2), .req_ready_o(ready2),
    .op0_i(op0_2), .op1_i(op1_2), .res_valid_o(rv2), .res_count_o(rc2), .busy_o(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    ready_m = cur_sel ? ready2 : ready1;
    rv_m    = cur_sel ? rv2 : rv1;
    rc_m    = cur_sel ? rc2 : {1'b0, rc1};
    busy_m  = cur_sel ? busy2 : busy1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
  endtask

  task automatic run_job(input vec_t v, output logic [4:0] count);
    logic [1:0] mask;
    logic [4:0] exp;
    int         n;
`ifdef STOCH_BIPOLAR_EN
    exp = v.eb;
`else
    exp = v.eu;
`endif
    mask    = v.req ? 2'b10 : 2'b01;
    cur_sel = v.sel;
    @(negedge clk);
    if (v.sel) begin
      if (v.req) op1_2 = v.op; else op0_2 = v.op;
      valid2 = mask;
    end else begin
      if (v.req) op1_1 = v.op; else op0_1 = v.op;
      valid1 = mask;
    end
    #1;
    check("ready", {30'd0, ready_m}, {30'd0, mask});
    @(posedge clk);
    #1;
    // Scramble operands and withdraw the request right after the accept edge.
    valid1 = 2'b00;
    valid2 = 2'b00;
    op0_1 = ~v.op; op1_1 = ~v.op; op0_2 = ~v.op; op1_2 = ~v.op;
    n = 0;
    while (n < 40 && rv_m == 2'b00) begin
      @(negedge clk);
      n++;
      if (n == 1) check("busy_after_accept", {31'd0, busy_m}, 32'd1);
    end
    check("latency", n, v.lat);
    check("res_valid", {30'd0, rv_m}, {30'd0, mask});
    check("res_count", {27'd0, rc_m}, {27'd0, exp});
    count = rc_m;
  endtask

  task automatic watch(input logic [1:0] v, input int n);
    acc_n = 0;
    saw11 = 1'b0;
    cur_sel = 1'b0;
    @(negedge clk);
    valid1 = v;
    for (int c = 0; c < 100 && acc_n < n; c++) begin
      #1;
      if (ready1 == 2'b11) saw11 = 1'b1;
      if (ready1 != 2'b00) begin
        acc_g[acc_n] = ready1;
        acc_t[acc_n] = c;
        acc_n++;
      end
      @(negedge clk);
    end
    valid1 = 2'b00;
    repeat (15) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] cnt;
    int         seen;
    vec_t       clean;

    n_total = 0;
    n_pass  = 0;
    rst_n   = 1'b1;
    valid1  = 2'b00; valid2 = 2'b00;
    op0_1   = 8'h00; op1_1  = 8'h00; op0_2 = 8'h00; op1_2 = 8'h00;
    cur_sel = 1'b0;

    //                sel   req   op     uni    bip    lat
    vecs[0]  = '{1'b0, 1'b0, 8'h00, 5'd0,  5'd8,  10};
    vecs[1]  = '{1'b0, 1'b1, 8'hFF, 5'd8,  5'd8,  10};
    vecs[2]  = '{1'b0, 1'b0, 8'hFF, 5'd8,  5'd8,  10};
    vecs[3]  = '{1'b0, 1'b1, 8'h11, 5'd4,  5'd7,  10};
    vecs[4]  = '{1'b0, 1'b0, 8'h0F, 5'd0,  5'd0,  10};
    vecs[5]  = '{1'b0, 1'b1, 8'h93, 5'd6,  5'd6,  10};
    vecs[6]  = '{1'b0, 1'b0, 8'h39, 5'd6,  5'd6,  10};
    vecs[7]  = '{1'b0, 1'b1, 8'h50, 5'd0,  5'd1,  10};
    vecs[8]  = '{1'b0, 1'b0, 8'h88, 5'd6,  5'd6,  10};
    vecs[9]  = '{1'b1, 1'b0, 8'h52, 5'd12, 5'd13, 18};
    vecs[10] = '{1'b1, 1'b1, 8'hFF, 5'd16, 5'd16, 18};
    vecs[11] = '{1'b1, 1'b0, 8'h31, 5'd10, 5'd12, 18};

    // Reset state, observed while reset is held.
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy1}, 32'd0);
    check("rst_res_valid", {30'd0, rv1}, 32'd0);
    check("rst_res_count", {28'd0, rc1}, 32'd0);
    valid1 = 2'b11;
    #1;
    check("rst_ready_contend", {30'd0, ready1}, 32'd1);
    valid1 = 2'b00;
    @(negedge clk);
    rst_n = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run_job(vecs[i], cnt);
      res_hist[i] = cnt;
    end
    check("reseed_deterministic", {27'd0, res_hist[1]}, {27'd0, res_hist[2]});

    // Contention from reset: alternate 0,1,0,1 at one accept per job period.
    do_reset();
    op0_1 = 8'h0F;
    op1_1 = 8'h11;
    watch(2'b11, 4);
    check("rr_accepts", acc_n, 4);
    check("rr_grant0", {30'd0, acc_g[0]}, 32'd1);
    check("rr_grant1", {30'd0, acc_g[1]}, 32'd2);
    check("rr_grant2", {30'd0, acc_g[2]}, 32'd1);
    check("rr_grant3", {30'd0, acc_g[3]}, 32'd2);
    check("rr_gap01", acc_t[1] - acc_t[0], 11);
    check("rr_gap12", acc_t[2] - acc_t[1], 11);
    check("rr_gap23", acc_t[3] - acc_t[2], 11);
    check("rr_never_both", {31'd0, saw11}, 32'd0);

    // Back-to-back requests on requester 1 only.
    watch(2'b10, 3);
    check("b2b_accepts", acc_n, 3);
    check("b2b_grant", {30'd0, acc_g[2]}, 32'd2);
    check("b2b_gap01", acc_t[1] - acc_t[0], 11);
    check("b2b_gap12", acc_t[2] - acc_t[1], 11);

    // Reset in the fourth RUN cycle aborts the job silently.
    cur_sel = 1'b0;
    @(negedge clk);
    op0_1  = 8'hFF;
    valid1 = 2'b01;
    @(posedge clk);
    #1;
    valid1 = 2'b00;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_busy", {31'd0, busy1}, 32'd0);
    check("abort_res_valid", {30'd0, rv1}, 32'd0);
    check("abort_res_count", {28'd0, rc1}, 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (rv1 != 2'b00) seen++;
    end
    check("abort_no_result", seen, 0);
    clean = '{1'b0, 1'b0, 8'h93, 5'd6, 5'd6, 10};
    run_job(clean, cnt);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/stoch_mul_sched.md
# stoch_mul_sched

Scheduler and arbiter for the shared stochastic multiplier datapath. Two requesters submit 4-bit operand pairs over a valid/ready handshake. The block grants one request at a time, round-robin. For each grant it reseeds the two 31-bit LFSRs, generates a fixed-length stochastic bitstream window and counts the product ones. It then returns the count to the granted requester with a one-cycle result strobe.

## Interface
Parameters:
- WIN_LOG2, default 3: window length is 2^WIN_LOG2 bitstream cycles; legal range 1..4.
- SEED_A, default 31'd1: reseed value for LFSR A; must be non-zero.
- SEED_B, default 31'd2: reseed value for LFSR B; must be non-zero and differ from SEED_A.

Ports:
- clk, input, 1: clock; all state changes on the rising edge.
- rst_n, input, 1: reset, asynchronous, active-high.
- req_valid, input, 2: bit i high when requester i presents an operand pair.
- req_ready, output, 2: bit i high when requester i is accepted this cycle; at most one bit high.
- op0, input, 8: requester 0 operands; [3:0] is probability A, [7:4] is probability B.
- op1, input, 8: requester 1 operands, same layout as op0.
- res_valid, output, 2: one-cycle strobe to the owning requester.
- res_count, output, WIN_LOG2+1: number of ones in the product window, range 0..2^WIN_LOG2.
- busy, output, 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - grant = round-robin pick among asserted req_valid bits.
  - req_ready[grant] = req_valid[grant]; req_ready is combinational from state, req_valid and last_grant.
  - On handshake (req_valid[i] & req_ready[i]): latch op_i, record owner = i, set last_grant = i, go to LOAD.
- Round-robin rule:
  - If both requesters are valid, grant goes to the requester that is not last_grant.
  - If one requester is valid, it wins.
  - last_grant resets to 1, so requester 0 wins the first contention.
- LOAD (1 cycle): LFSR A <= SEED_A, LFSR B <= SEED_B, bit counter <= 0, ones counter <= 0. Go to RUN.
- RUN (2^WIN_LOG2 cycles). Each cycle:
  - sa = (lfsrA[3:0] < latched A), unsigned compare.
  - sb = (lfsrB[3:0] < latched B), unsigned compare.
  - p = product bit (see Configuration).
  - Ones counter += p; counter width WIN_LOG2+1, cannot overflow.
  - Both LFSRs shift: lfsr <= {lfsr[29:0], lfsr[27]^lfsr[30]}.
  - Bit counter increments. After the last bit, go to DONE.
- DONE (1 cycle):
  - res_valid[owner] = 1; res_count = final ones count.
  - Next state IDLE. No request is accepted during DONE.
- res_count holds its value until the next DONE.
- LFSRs and operands are frozen outside LOAD/RUN.
- Operand inputs are ignored after the accept edge.
- req_valid deasserting mid-operation has no effect on the running job.

## Timing
- Reset values:
  - State IDLE; busy 0; req_ready follows IDLE rules immediately after reset.
  - res_valid 2'b00; res_count 0; last_grant 1.
  - LFSR A = SEED_A; LFSR B = SEED_B.
- Latency: accept at edge T; LOAD in cycle T+1; RUN in cycles T+2..T+1+2^W; res_valid high in cycle T+2+2^W.
- With W=3, res_valid is high 10 cycles after the accept edge.
- Throughput: the earliest next accept is in the cycle after DONE. Period is 2^W+3 cycles.
- Reset asserted mid-operation: abort immediately. No res_valid is issued and the request is lost; the requester must resubmit.
- Simultaneous requests: exactly one is accepted per IDLE cycle. The loser's req_valid must remain high until it is accepted.

## Configuration
- STOCH_BIPOLAR_EN defined: p = ~(sa ^ sb), the bipolar XNOR multiply.
- STOCH_BIPOLAR_EN undefined: p = sa & sb, the unipolar AND multiply.
- All other behaviour is identical in both builds.

## Test plan
- Reset, then op0=8'h00 and req_valid=2'b01 with W=3:
  - req_ready=2'b01 in the same cycle.
  - res_valid=2'b01 exactly 10 cycles after accept.
  - res_count=8 with STOCH_BIPOLAR_EN; 0 without.
- Both requesters valid from reset:
  - Requester 0 is served first, then requester 1.
  - With both held valid, grants alternate 0,1,0,1.
  - req_ready is never 2'b11.
- op0=8'hFF repeated twice with identical seeds: both res_count values are equal (deterministic reseed). In the unipolar build the value is ≤8.
- Assert rst_n during cycle 4 of RUN: busy=0 next cycle, no res_valid, res_count=0, and the next accept starts a clean job.
- Change op0 and drop req_valid one cycle after accept: the result matches the originally latched operands.
- Back-to-back requests on requester 1: accepts occur 11 cycles apart (W=3), and no request is accepted during LOAD, RUN or DONE.
